// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: condition codes, flag bit positions
// and the condition evaluator used for both branches and conditional selects.
package alu_pkg;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_LT = 1;

  // Encodings 7-15 are deliberately left unnamed: they all mean "never".
  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_LT = 4'd3,
    COND_GE = 4'd4,
    COND_LE = 4'd5,
    COND_GT = 4'd6
  } cond_e;

  function automatic logic cond_eval(input cond_e cond, input logic [1:0] f);
    logic r;
    r = 1'b0;
    case (cond)
      COND_AL: r = 1'b1;
      COND_EQ: r = f[FLAG_EQ];
      COND_NE: r = ~f[FLAG_EQ];
      COND_LT: r = f[FLAG_LT];
      COND_GE: r = ~f[FLAG_LT];
      COND_LE: r = f[FLAG_LT] | f[FLAG_EQ];
      COND_GT: r = ~f[FLAG_LT] & ~f[FLAG_EQ];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer; entry0 drives the output, entry1 catches
// the op accepted while the output is stalled. in_ready comes straight from a flop.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         e0_valid, e1_valid;
  logic [W-1:0] e0_data, e1_data;
  logic         acc, xfer;

  assign in_ready  = ~e1_valid;
  assign out_valid = e0_valid;
  assign out_data  = e0_data;
  assign acc       = in_valid & ~e1_valid;
  assign xfer      = e0_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_valid <= 1'b0;
      e1_valid <= 1'b0;
      e0_data  <= '0;
      e1_data  <= '0;
    end else if (flush) begin
      e0_valid <= 1'b0;
      e1_valid <= 1'b0;
    end else if (e1_valid) begin
      if (xfer) begin
        e0_data  <= e1_data;
        e1_valid <= 1'b0;
      end
    end else if (e0_valid) begin
      // With one entry held, a simultaneous accept+transfer replaces entry0 in place.
      if (acc && xfer) begin
        e0_data <= in_data;
      end else if (acc) begin
        e1_data  <= in_data;
        e1_valid <= 1'b1;
      end else if (xfer) begin
        e0_valid <= 1'b0;
      end
    end else if (acc) begin
      e0_data  <= in_data;
      e0_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: buffers ALU results, resolves compare-and-branch into a
// redirect pulse and holds the flags register. Define ALU_RESULT_STAGE_PERF_EN for perf counters.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_res,
  input  logic [1:0]      in_cmp,
  input  logic            in_is_cmp,
  input  logic            in_is_branch,
  input  logic [3:0]      in_cond,
  input  logic [XLEN-1:0] in_target,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [RD_W-1:0] out_rd,
  output logic            out_we,
  input  logic [3:0]      sel_cond,
  output logic            cond_true,
  output logic [1:0]      flags,
`ifdef ALU_RESULT_STAGE_PERF_EN
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_taken,
`endif
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int PW = XLEN + RD_W + 1;

  logic          accept;
  logic          taken;
  logic [PW-1:0] buf_out;

  assign accept = in_valid & in_ready & ~flush;
  assign taken  = accept & in_is_branch & cond_eval(cond_e'(in_cond), in_cmp);

  skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid & ~flush),
    .in_ready  (in_ready),
    .in_data   ({in_res, in_rd, in_we}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign {out_res, out_rd, out_we} = buf_out;

  // No same-cycle bypass: selects see only flags from earlier accepted compares.
  assign cond_true = cond_eval(cond_e'(sel_cond), flags);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags       <= 2'b00;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      if (accept && in_is_cmp) flags <= in_cmp;
      redirect    <= taken;
      redirect_pc <= taken ? in_target : '0;
    end
  end

`ifdef ALU_RESULT_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_taken    <= '0;
    end else begin
      if (accept && in_is_branch) perf_branches <= perf_branches + 32'd1;
      if (taken) perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized scoreboard bench for alu_result_stage; expected writebacks are queued at
// accept time and popped by an independent monitor on every output transfer.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready;
  logic [31:0] in_res, in_target, out_res, redirect_pc;
  logic [1:0]  in_cmp, flags;
  logic        in_is_cmp, in_is_branch, in_we;
  logic [3:0]  in_cond, sel_cond;
  logic [4:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_we, cond_true, redirect;
`ifdef ALU_RESULT_STAGE_PERF_EN
  logic [31:0] perf_branches, perf_taken;
  logic [31:0] m_branches, m_taken;
`endif

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  logic [37:0] sb[$];
  logic [1:0]  m_flags;
  logic        exp_redirect;
  logic [31:0] exp_pc;
  logic        m_ready;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_cmp(in_cmp), .in_is_cmp(in_is_cmp), .in_is_branch(in_is_branch),
    .in_cond(in_cond), .in_target(in_target), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_rd(out_rd),
    .out_we(out_we), .sel_cond(sel_cond), .cond_true(cond_true), .flags(flags),
`ifdef ALU_RESULT_STAGE_PERF_EN
    .perf_branches(perf_branches), .perf_taken(perf_taken),
`endif
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // Reference condition semantics stated in terms of the comparison outcome.
  function automatic logic ref_cond(input int c, input logic [1:0] f);
    bit eq, lt;
    eq = f[0];
    lt = f[1];
    if (c == 0) return 1'b1;
    if (c == 1) return eq;
    if (c == 2) return !eq;
    if (c == 3) return lt;
    if (c == 4) return !lt;
    if (c == 5) return lt || eq;
    if (c == 6) return !lt && !eq;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state against the model and retires transferred entries.
  always @(negedge clk) begin
    if (mon_en) begin
      m_ready = (sb.size() < 2);
      checkOutput("in_ready", 64'(in_ready), 64'(m_ready));
      checkOutput("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        checkOutput("out_res", 64'(out_res), 64'(sb[0][37:6]));
        checkOutput("out_rd", 64'(out_rd), 64'(sb[0][5:1]));
        checkOutput("out_we", 64'(out_we), 64'(sb[0][0]));
        if (out_ready) void'(sb.pop_front());
      end
      checkOutput("flags", 64'(flags), 64'(m_flags));
      checkOutput("cond_true", 64'(cond_true), 64'(ref_cond(int'(sel_cond), m_flags)));
      checkOutput("redirect", 64'(redirect), 64'(exp_redirect));
      if (exp_redirect) checkOutput("redirect_pc", 64'(redirect_pc), 64'(exp_pc));
`ifdef ALU_RESULT_STAGE_PERF_EN
      checkOutput("perf_branches", 64'(perf_branches), 64'(m_branches));
      checkOutput("perf_taken", 64'(perf_taken), 64'(m_taken));
`endif
    end
  end

  // Drives one cycle of inputs, then updates the model with what the next edge should do.
  task automatic applyStimulus(input logic v, input logic [31:0] res, input logic [4:0] rd,
                               input logic we, input logic [1:0] cmp, input logic is_cmp,
                               input logic is_br, input logic [3:0] cond, input logic [31:0] tgt,
                               input logic fl, input logic ordy, input logic [3:0] sel,
                               output logic acc);
    @(posedge clk);
    #1;
    in_valid = v; in_res = res; in_rd = rd; in_we = we; in_cmp = cmp;
    in_is_cmp = is_cmp; in_is_branch = is_br; in_cond = cond; in_target = tgt;
    flush = fl; out_ready = ordy; sel_cond = sel;
    @(negedge clk);
    #1;
    acc = v && m_ready && !fl;
    if (fl) sb.delete();
    else if (acc) sb.push_back({res, rd, we});
    exp_redirect = acc && is_br && ref_cond(int'(cond), cmp);
    exp_pc = tgt;
    if (acc && is_cmp) m_flags = cmp;
`ifdef ALU_RESULT_STAGE_PERF_EN
    if (acc && is_br) m_branches++;
    if (exp_redirect) m_taken++;
`endif
  endtask

  task automatic modelReset();
    sb.delete();
    m_flags = 2'b00;
    exp_redirect = 1'b0;
    exp_pc = '0;
`ifdef ALU_RESULT_STAGE_PERF_EN
    m_branches = '0;
    m_taken = '0;
`endif
  endtask

  task automatic idleInputs();
    in_valid = 0; in_res = '0; in_rd = '0; in_we = 0; in_cmp = '0; in_is_cmp = 0;
    in_is_branch = 0; in_cond = '0; in_target = '0; flush = 0; out_ready = 0; sel_cond = '0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_flags", 64'(flags), 64'd0);
    checkOutput("rst_redirect", 64'(redirect), 64'd0);
    checkOutput("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    checkOutput("rst_out_res", 64'(out_res), 64'd0);
    checkOutput("rst_out_rd", 64'(out_rd), 64'd0);
    checkOutput("rst_out_we", 64'(out_we), 64'd0);
`ifdef ALU_RESULT_STAGE_PERF_EN
    checkOutput("rst_perf_branches", 64'(perf_branches), 64'd0);
    checkOutput("rst_perf_taken", 64'(perf_taken), 64'd0);
`endif
  endtask

  initial begin
    logic acc;
    int tries;
    rst_n = 1'b0;
    idleInputs();
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    checkResetState();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single op through an empty buffer.
    applyStimulus(1, 32'h1234, 5'd3, 1, 2'b00, 0, 0, 4'd0, 32'h0, 0, 1, 4'd0, acc);
    applyStimulus(0, 32'h0, 5'd0, 0, 2'b00, 0, 0, 4'd0, 32'h0, 0, 1, 4'd0, acc);

    // Three back-to-back ops against a stalled output; each retried until accepted.
    for (int k = 0; k < 3; k++) begin
      tries = 0;
      do begin
        applyStimulus(1, 32'hA000 + k, 5'(k + 10), 1, 2'b00, 0, 0, 4'd0, 32'h0, 0,
                      (tries >= 3), 4'd0, acc);
        tries++;
      end while (!acc && tries < 10);
      checkOutput("bp_accept_bound", 64'(acc), 64'd1);
    end
    repeat (4) applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 0, 0, 1, 4'd0, acc);

    // Compare writes LT, then selects evaluate LT and GE against it.
    applyStimulus(1, 32'h5, 5'd1, 0, 2'b10, 1, 0, 4'd0, 0, 0, 1, 4'd3, acc);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 0, 0, 1, 4'd3, acc);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 0, 0, 1, 4'd4, acc);

    // Branches: NE taken, EQ not taken, code 9 never.
    applyStimulus(1, 32'h44, 5'd1, 1, 2'b00, 0, 1, 4'd2, 32'h400, 0, 1, 4'd0, acc);
    applyStimulus(1, 32'h48, 5'd1, 1, 2'b00, 0, 1, 4'd1, 32'h500, 0, 1, 4'd0, acc);
    applyStimulus(1, 32'h4C, 5'd1, 1, 2'b01, 0, 1, 4'd9, 32'h600, 0, 1, 4'd0, acc);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 0, 0, 1, 4'd0, acc);

    // Fill the buffer, then flush alongside a would-be taken branch that also compares.
    applyStimulus(1, 32'h1, 5'd2, 1, 2'b00, 0, 0, 4'd0, 0, 0, 0, 4'd0, acc);
    applyStimulus(1, 32'h2, 5'd2, 1, 2'b00, 0, 0, 4'd0, 0, 0, 0, 4'd0, acc);
    applyStimulus(1, 32'h3, 5'd2, 1, 2'b01, 1, 1, 4'd0, 32'h700, 1, 0, 4'd0, acc);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 4'd0, acc);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, 5'($urandom), 1'($urandom),
                    2'($urandom_range(0, 2)), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, 4'($urandom), $urandom,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                    4'($urandom), acc);
    end

    // Stall with entries held, then assert reset asynchronously mid-cycle.
    applyStimulus(1, 32'hBEEF, 5'd7, 1, 2'b10, 1, 1, 4'd0, 32'h900, 0, 0, 4'd0, acc);
    applyStimulus(1, 32'hCAFE, 5'd8, 1, 2'b00, 0, 0, 4'd0, 0, 0, 0, 4'd0, acc);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    checkOutput("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkResetState();
    idleInputs();
    modelReset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom, 5'($urandom), 1'($urandom),
                    2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 4'($urandom),
                    $urandom, 1'b0, 1'($urandom), 4'($urandom), acc);
    end
    repeat (4) applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 0, 0, 1, 4'd0, acc);
    checkOutput("drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
